// File: rtl/sram_bist_march.sv
// March C- BIST engine testing NUM_BANKS single-port SRAM banks in parallel with a sticky per-bank fail vector.
// Optional first-failure diagnostic capture is enabled by defining BIST_DIAG_EN.
module sram_bist_march #(
    parameter int NUM_BANKS = 8,
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 8
) (
    input  logic                          hclk,
    input  logic                          hreset,
    input  logic                          bist_en,
    output logic                          bist_busy,
    output logic                          bist_done,
    output logic [NUM_BANKS-1:0]          bist_fail,
    output logic                          sram_cen,
    output logic                          sram_wen,
    output logic [ADDR_W-1:0]             sram_addr,
    output logic [NUM_BANKS*DATA_W-1:0]   sram_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0]   sram_rdata
`ifdef BIST_DIAG_EN
    ,
    output logic                                               diag_valid,
    output logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] diag_bank,
    output logic [ADDR_W-1:0]                                  diag_addr,
    output logic [2:0]                                         diag_elem
`endif
);

    typedef enum logic [3:0] {IDLE, E0, E1, E2, E3, E4, E5, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_enD;
    logic [ADDR_W:0]        r_cnt;
    logic                   r_phase;
    logic                   r_done;
    logic [NUM_BANKS-1:0]   r_fail;
    logic                   r_rvalid;
    logic                   r_expBit;
    logic                   w_start;
    logic                   w_inMarch;
    logic                   w_isRead;
    logic                   w_step;
    logic                   w_last;
    logic                   w_down;
    logic                   w_rbit;
    logic                   w_wbit;
    logic [2:0]             w_elem;
    logic [NUM_BANKS-1:0]   w_mism;

    assign w_start   = bist_en && !r_enD && (r_state == IDLE);
    assign w_last    = (r_cnt == LAST);
    assign bist_done = r_done;
    assign bist_fail = r_fail;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:                   if (w_start) w_next = E0;
            E0, E1, E2, E3, E4, E5: begin
                if (!bist_en)              w_next = IDLE;
                else if (w_step && w_last) w_next = state_t'(r_state + 4'd1);
            end
            DRAIN:                  w_next = bist_en ? DONE : IDLE;
            DONE:                   if (!bist_en) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    // E0/E5 issue one op per address; E1..E4 issue a read/write pair, phase selecting which.
    always_comb begin
        bist_busy  = 1'b0;
        sram_cen   = 1'b1;
        sram_wen   = 1'b1;
        sram_addr  = '0;
        sram_wdata = '0;
        w_inMarch  = (r_state >= E0) && (r_state <= E5);
        w_elem     = 3'(r_state - E0);
        w_down     = (r_state == E3) || (r_state == E4);
        w_rbit     = (r_state == E2) || (r_state == E4);
        w_wbit     = (r_state == E1) || (r_state == E3);
        w_isRead   = 1'b0;
        w_step     = 1'b0;
        if (w_inMarch) begin
            bist_busy = 1'b1;
            sram_cen  = 1'b0;
            sram_addr = w_down ? ~r_cnt[ADDR_W-1:0] : r_cnt[ADDR_W-1:0];
            w_isRead  = (r_state == E5) || ((r_state != E0) && !r_phase);
            w_step    = (r_state == E0) || (r_state == E5) || r_phase;
            sram_wen  = w_isRead;
            if (!w_isRead) sram_wdata = {(NUM_BANKS*DATA_W){w_wbit}};
        end else if (r_state == DRAIN) begin
            bist_busy = 1'b1;
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++)
            w_mism[b] = r_rvalid && (sram_rdata[b*DATA_W +: DATA_W] != {DATA_W{r_expBit}});
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_enD    <= 1'b0;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
            r_done   <= 1'b0;
            r_fail   <= '0;
            r_rvalid <= 1'b0;
            r_expBit <= 1'b0;
        end else begin
            r_enD    <= bist_en;
            r_rvalid <= w_isRead;
            r_expBit <= w_rbit;
            if (w_inMarch) begin
                if (w_step) begin
                    r_phase <= 1'b0;
                    r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                end else begin
                    r_phase <= 1'b1;
                end
            end else begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end
            if (w_start) begin
                r_done <= 1'b0;
                r_fail <= '0;
            end else begin
                r_fail <= r_fail | w_mism;
                if (r_state == DRAIN && bist_en) r_done <= 1'b1;
            end
        end
    end

`ifdef BIST_DIAG_EN
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic              r_diagValid;
    logic [BANK_W-1:0] r_diagBank;
    logic [ADDR_W-1:0] r_diagAddr;
    logic [2:0]        r_diagElem;
    logic [ADDR_W-1:0] r_raddr;
    logic [2:0]        r_relem;
    logic [BANK_W-1:0] w_lowBank;

    always_comb begin
        w_lowBank = '0;
        for (int b = NUM_BANKS - 1; b >= 0; b--)
            if (w_mism[b]) w_lowBank = BANK_W'(b);
    end

    // Address and element travel with the read so the capture names the failing op, not the current one.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_diagValid <= 1'b0;
            r_diagBank  <= '0;
            r_diagAddr  <= '0;
            r_diagElem  <= '0;
            r_raddr     <= '0;
            r_relem     <= '0;
        end else begin
            r_raddr <= sram_addr;
            r_relem <= w_elem;
            if (w_start) begin
                r_diagValid <= 1'b0;
                r_diagBank  <= '0;
                r_diagAddr  <= '0;
                r_diagElem  <= '0;
            end else if (!r_diagValid && (|w_mism)) begin
                r_diagValid <= 1'b1;
                r_diagBank  <= w_lowBank;
                r_diagAddr  <= r_raddr;
                r_diagElem  <= r_relem;
            end
        end
    end

    assign diag_valid = r_diagValid;
    assign diag_bank  = r_diagBank;
    assign diag_addr  = r_diagAddr;
    assign diag_elem  = r_diagElem;
`endif

endmodule
